alu_ctrl_sequencer: RTL and testbench

// - Registered, handshaked ALU-control stage for the multi-cycle datapath. Decodes {ALUOp, funct} to ALUCnt.
// - Holds multi-cycle ops (MUL/DIV) for a programmable number of cycles; the ALU result is valid when out_valid is high.
// - Sits between the main control unit (upstream) and the ALU/EX stage (downstream).

---
 rtl/alu_ctrl_pkg.sv | 43 ++++
 rtl/alu_ctrl_decode.sv | 49 ++++
 rtl/alu_ctrl_sequencer.sv | 118 +++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// alu_ctrl_pkg : shared encodings for the ALU-control sequencer
// Rev 1.0
// ============================================================================
package alu_ctrl_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_SLT   = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;

  localparam logic [5:0] F_0   = 6'd0;
  localparam logic [5:0] F_1   = 6'd1;
  localparam logic [5:0] F_2   = 6'd2;
  localparam logic [5:0] F_3   = 6'd3;
  localparam logic [5:0] F_4   = 6'd4;
  localparam logic [5:0] F_5   = 6'd5;
  localparam logic [5:0] F_6   = 6'd6;
  localparam logic [5:0] F_7   = 6'd7;
  localparam logic [5:0] F_MUL = 6'd8;
  localparam logic [5:0] F_DIV = 6'd9;

  localparam logic [3:0] CNT_ADD     = 4'b0000;
  localparam logic [3:0] CNT_SUB     = 4'b0001;
  localparam logic [3:0] CNT_AND     = 4'b0010;
  localparam logic [3:0] CNT_OR      = 4'b0011;
  localparam logic [3:0] CNT_XOR     = 4'b0100;
  localparam logic [3:0] CNT_NOR     = 4'b0101;
  localparam logic [3:0] CNT_SLL     = 4'b0110;
  localparam logic [3:0] CNT_SLT     = 4'b0111;
  localparam logic [3:0] CNT_MUL     = 4'b1000;
  localparam logic [3:0] CNT_DIV     = 4'b1001;
  localparam logic [3:0] CNT_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// alu_ctrl_decode : combinational {ALUOp, funct} -> {ALUCnt, multi, illegal}
// Rev 1.0
// ============================================================================
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int CNT_W   = 4
) (
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CNT_W-1:0]   alu_cnt,
  output logic               multi,
  output logic               illegal
);

  always_comb begin
    alu_cnt = CNT_W'(CNT_ILLEGAL);
    multi   = 1'b0;
    illegal = 1'b1;
    case (aluop)
      ALUOP_W'(OP_RTYPE): begin
        illegal = 1'b0;
        case (funct)
          FUNCT_W'(F_0):   alu_cnt = CNT_W'(CNT_ADD);
          FUNCT_W'(F_1):   alu_cnt = CNT_W'(CNT_SUB);
          FUNCT_W'(F_2):   alu_cnt = CNT_W'(CNT_NOR);
          FUNCT_W'(F_3):   alu_cnt = CNT_W'(CNT_SLL);
          FUNCT_W'(F_4):   alu_cnt = CNT_W'(CNT_SLT);
          FUNCT_W'(F_5):   alu_cnt = CNT_W'(CNT_OR);
          FUNCT_W'(F_6):   alu_cnt = CNT_W'(CNT_XOR);
          FUNCT_W'(F_7):   alu_cnt = CNT_W'(CNT_AND);
          FUNCT_W'(F_MUL): begin alu_cnt = CNT_W'(CNT_MUL); multi = 1'b1; end
          FUNCT_W'(F_DIV): begin alu_cnt = CNT_W'(CNT_DIV); multi = 1'b1; end
          default:         begin alu_cnt = CNT_W'(CNT_ILLEGAL); illegal = 1'b1; end
        endcase
      end
      ALUOP_W'(OP_SUB): begin alu_cnt = CNT_W'(CNT_SUB); illegal = 1'b0; end
      ALUOP_W'(OP_SLT): begin alu_cnt = CNT_W'(CNT_SLT); illegal = 1'b0; end
      ALUOP_W'(OP_ADD): begin alu_cnt = CNT_W'(CNT_ADD); illegal = 1'b0; end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// alu_ctrl_sequencer : handshaked ALU-control stage with MUL/DIV hold timer.
// Optional sticky illegal-op trap under macro ALU_CTRL_TRAP_EN.  Rev 1.0
// ============================================================================
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W   = 3,
  parameter int FUNCT_W   = 6,
  parameter int CNT_W     = 4,
  parameter int MD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   ALUCnt,
  output logic               multi,
  output logic               illegal
);

  localparam logic [7:0] C_MD_LOAD = 8'(MD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d;
  logic             multi_q, multi_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic             trap_q;
  logic             w_accept;
  logic [CNT_W-1:0] w_dec_cnt;
  logic             w_dec_multi;
  logic             w_dec_illegal;

  alu_ctrl_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W),
    .CNT_W   (CNT_W)
  ) u_decode (
    .aluop   (ALUOp),
    .funct   (funct),
    .alu_cnt (w_dec_cnt),
    .multi   (w_dec_multi),
    .illegal (w_dec_illegal)
  );

  // OUT forwards out_ready so a consumed result can be replaced in the same cycle.
  assign in_ready = ~rst & ~trap_q &
                    ((state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready));
  assign w_accept = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_cnt_d = alu_cnt_q;
    multi_d   = multi_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: ;
      ST_BUSY: begin
        if (cnt_q == 8'd0) state_d = ST_OUT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_OUT:  if (out_ready && !w_accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (w_accept) begin
      alu_cnt_d = w_dec_cnt;
      multi_d   = w_dec_multi;
      illegal_d = w_dec_illegal;
      cnt_d     = C_MD_LOAD;
      state_d   = w_dec_multi ? ST_BUSY : ST_OUT;
    end
    out_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      alu_cnt_q   <= '0;
      multi_q     <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_cnt_q   <= alu_cnt_d;
      multi_q     <= multi_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALU_CTRL_TRAP_EN
  logic trap_d;
  assign trap_d = trap_q | (w_accept & w_dec_illegal);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= trap_d;
  end
`else
  assign trap_q = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign ALUCnt    = alu_cnt_q;
  assign multi     = multi_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_ctrl_sequencer : directed + randomized bench with table-driven model
// Rev 1.0
// ============================================================================
module tb_alu_ctrl_sequencer;

  localparam int MD = 8;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, multi, illegal;
  logic [2:0] ALUOp;
  logic [5:0] funct;
  logic [3:0] ALUCnt;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  alu_ctrl_sequencer #(
    .ALUOP_W(3), .FUNCT_W(6), .CNT_W(4), .MD_CYCLES(MD)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .ALUCnt(ALUCnt), .multi(multi), .illegal(illegal)
  );

  // Reference result packed as {code, multi, illegal}.
  function automatic logic [5:0] ref_decode(input logic [2:0] op, input logic [5:0] f);
    logic [3:0] rtab [10];
    logic [3:0] optab [4];
    rtab  = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h3, 4'h4, 4'h2, 4'h8, 4'h9};
    optab = '{4'h0, 4'h1, 4'h7, 4'h0};
    if (op == 3'd0) begin
      if (f < 6'd10) return {rtab[f], (f >= 6'd8), 1'b0};
      return {4'hF, 2'b01};
    end
    if (op < 3'd4) return {optab[op[1:0]], 2'b00};
    return {4'hF, 2'b01};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb();
    logic [5:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_spurious", {31'b0, out_valid}, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_item", {26'b0, ALUCnt, multi, illegal}, {26'b0, e});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_decode(ALUOp, funct));
    end
  endtask

  task automatic tick();
    #1 sb();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] tops  [11];
    logic [5:0] tfun  [11];
    logic [3:0] tcode [11];
    tops  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
    tfun  = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0};
    tcode = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h3, 4'h4, 4'h2, 4'h1, 4'h7, 4'h0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ALUOp = '0; funct = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alucnt", ALUCnt, 0);
    chk("rst_multi", multi, 0);
    chk("rst_illegal", illegal, 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // Full decode table streamed at one per cycle.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      ALUOp = tops[i]; funct = tfun[i];
      #1 chk("tbl_in_ready", in_ready, 1);
      tick();
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_code", ALUCnt, tcode[i]);
    end
    in_valid = 1'b0;
    tick();

    // MUL occupies the ALU for MD cycles.
    in_valid = 1'b1; ALUOp = 3'd0; funct = 6'd8;
    tick();
    for (int i = 0; i < MD; i++) begin
      ALUOp = 3'($urandom_range(0, 7)); funct = 6'($urandom_range(0, 15));
      #1 chk("busy_out_valid", out_valid, 0);
      chk("busy_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("mul_out_valid", out_valid, 1);
    chk("mul_code", ALUCnt, 4'h8);
    chk("mul_multi", multi, 1);
    tick();

    // Backpressure hold, then bubble-free handoff.
    out_ready = 1'b0; in_valid = 1'b1; ALUOp = 3'd0; funct = 6'd5;
    tick();
    ALUOp = 3'd1; funct = 6'($urandom_range(0, 63));
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_code", ALUCnt, 4'h3);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_pass_in_ready", in_ready, 1);
    tick();
    chk("handoff_valid", out_valid, 1);
    chk("handoff_code", ALUCnt, 4'h1);
    in_valid = 1'b0;
    tick();

    // Illegal encoding.
    in_valid = 1'b1; ALUOp = 3'd7; funct = 6'($urandom_range(0, 63));
    tick();
    chk("ill_code", ALUCnt, 4'hF);
    chk("ill_flag", illegal, 1);
    ALUOp = 3'd3;
`ifdef ALU_CTRL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("trap_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    rst = 1'b1; exp_q.delete();
    tick(); tick();
    rst = 1'b0;
`else
    #1 chk("noTrap_in_ready", in_ready, 1);
    tick();
    chk("noTrap_valid", out_valid, 1);
    chk("noTrap_code", ALUCnt, 4'h0);
    chk("noTrap_illegal", illegal, 0);
    in_valid = 1'b0;
    tick();
`endif

    // Reset three cycles into a DIV abandons it.
    in_valid = 1'b1; ALUOp = 3'd0; funct = 6'd9;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; exp_q.delete();
    #1 chk("divrst_out_valid", out_valid, 0);
    chk("divrst_in_ready", in_ready, 0);
    tick(); tick();
    rst = 1'b0;
    #1 chk("divrst_idle", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      chk("divrst_no_late", out_valid, 0);
      tick();
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_CTRL_TRAP_EN
      ALUOp = 3'($urandom_range(0, 3));
      funct = 6'($urandom_range(0, 9));
`else
      ALUOp = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      funct = 6'($urandom_range(0, 11));
`endif
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) tick();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
